layer3_mac_accum: RTL and testbench
===================================

Name: layer3_mac_accum

Overview:
Datapath stage directly downstream of the layer-3 controller. Consumes the controller's per-term strobes (temp_zero, WE_2, BRAM2_addr) plus the BRAM1 pixel word and weight-ROM word those addresses fetched. Performs signed multiply-accumulate over each output group, then rescales, clamps and writes one result word to BRAM2 per group. Pipelined, with one term accepted per cycle.

Parameters:
DW, 8, pixel, weight and output word width (signed two's complement)
ACC_W, 24, accumulator width (signed)
FRAC, 4, arithmetic right shift applied to the accumulator before clamping
RD_LAT, 1, read latency in cycles of BRAM1 and the weight ROM (1 or 2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
in_valid  in  1  one term issued this cycle; driven by the controller's temp_zero
WE_2  in  1  term issued this cycle is the last term of its group
BRAM2_addr  in  10  destination address of the current group, sampled with in_valid
pixel_in  in  DW  BRAM1 read data, valid RD_LAT cycles after its in_valid
weight_in  in  DW  weight-ROM read data, valid RD_LAT cycles after its in_valid
BRAM2_din  out  DW  result word
BRAM2_we  out  1  one-cycle write strobe
BRAM2_waddr  out  10  write address, aligned with BRAM2_we
write_count  out  10  number of completed writes, wraps from 1023 to 0
busy  out  1  at least one pipeline stage holds a valid term

Behaviour:
- Reset: rst=0 asynchronously clears all state.
  - Outputs BRAM2_din=0, BRAM2_we=0, BRAM2_waddr=0, write_count=0, busy=0.
  - Accumulator=0, first_flag=1.
  - In-flight terms are dropped.
  - A reset in the middle of a group discards the partial sum; no write is generated for that group.
- Stage D (delay line): RD_LAT registers carry {in_valid, WE_2, BRAM2_addr}, so these control bits line up with pixel_in/weight_in.
- Stage P: when the delayed valid is 1, prod <= signed(pixel_in) * signed(weight_in) (2*DW bits), with the flags carried alongside. When the delayed valid is 0, the stage is marked invalid and prod holds its value.
- Stage A, only when stage P is valid:
  - sum = (first_flag ? 0 : acc) + sign-extended prod.
  - sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1]; it never wraps.
  - acc <= sum.
  - first_flag <= last (the carried WE_2 bit).
- Write, on a term with last=1, same edge as the acc update:
  - BRAM2_we <= 1.
  - BRAM2_waddr <= the carried address.
  - BRAM2_din <= clamp(sum >>> FRAC).
  - write_count increments.
- BRAM2_we is low on every other cycle; BRAM2_din and BRAM2_waddr hold their values.
- Latency: a last term with in_valid=1 at edge t produces BRAM2_we=1 in the cycle after edge t+RD_LAT+2 (t+3 for RD_LAT=1).
- Gaps: in_valid=0 cycles, in any number, leave acc and first_flag untouched.
- Single-term group: a term with WE_2=1 while first_flag=1 writes that term's product alone.
- Back-to-back groups: a last term followed immediately by a term of the next group needs no bubble. The next term starts from 0.
- busy = OR of the valid bits of stages D and P.
- Clamp: defined by the optional feature below.

Optional Feature:
LAYER3_RELU_EN
- Defined: the clamp range is [0, 2^(DW-1)-1]. Negative results write 0 (ReLU fused with saturation).
- Undefined: the clamp range is [-2^(DW-1), 2^(DW-1)-1]. Negative results are written in two's complement.

Test Plan:
- Basic group (DW=8, FRAC=4, RD_LAT=1): 4 terms, pixel=16, weight=16, WE_2 on the 4th, addr=0x05 -> one BRAM2_we pulse, din=64, waddr=0x05, write_count=1.
- Latency: a single term (pixel=32, weight=8, WE_2=1) at edge t -> BRAM2_we high for exactly one cycle after edge t+3, din=16. busy falls afterwards.
- Saturation: 4 terms of pixel=127, weight=127 -> din=127.
- Sign: 4 terms of pixel=-16, weight=16 -> din=0 with LAYER3_RELU_EN, din=0xC0 (-64) without.
- Gaps and back-to-back groups:
  - Group A: 2 terms of 16x16 with in_valid=0 cycles between them, WE_2 on the 2nd, immediately followed by group B: 1 term of 16x16 with WE_2.
  - Required: din=32, then din=16. B's sum is independent of A.
- Reset mid-group: 2 terms of 16x16, pull rst low for 1 cycle, then 1 term 16x16 with WE_2=1 -> exactly one write, din=16, write_count=1.

Source files
------------

// File: rtl/layer3_mac_accum.sv
// layer3_mac_accum
// Signed multiply-accumulate stage that sits behind the layer-3 controller.
// Each issued term is one pixel/weight pair. The stage sums the products of an
// output group, rescales the sum, clamps it and writes one word to BRAM2.
// Pipeline: D (read-latency delay line) -> P (multiply) -> A (accumulate/write).
// One term is accepted every cycle and no bubble is needed between groups.
//
// Optional build macro: LAYER3_RELU_EN
//   defined   : output clamp range is [0, 2^(DW-1)-1], so ReLU is fused in
//   undefined : output clamp range is [-2^(DW-1), 2^(DW-1)-1]
module layer3_mac_accum #(
    parameter int DW     = 8,
    parameter int ACC_W  = 24,
    parameter int FRAC   = 4,
    parameter int RD_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          WE_2,
    input  logic [9:0]    BRAM2_addr,
    input  logic [DW-1:0] pixel_in,
    input  logic [DW-1:0] weight_in,
    output logic [DW-1:0] BRAM2_din,
    output logic          BRAM2_we,
    output logic [9:0]    BRAM2_waddr,
    output logic [9:0]    write_count,
    output logic          busy
);

    // The accumulator gets one guard bit so that an overflow can be seen
    // before it is saturated back into ACC_W bits.
    localparam int SW = ACC_W + 1;
    localparam int PW = 2 * DW;

    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // Output clamp bounds, expressed at accumulator width for comparison.
    localparam logic signed [ACC_W-1:0] OUT_MAX =
        {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
`ifdef LAYER3_RELU_EN
    localparam logic signed [ACC_W-1:0] OUT_MIN = '0;
`else
    localparam logic signed [ACC_W-1:0] OUT_MIN =
        {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
`endif

    // Stage D: control bits travel through RD_LAT registers.
    logic [RD_LAT-1:0] d_valid;
    logic [RD_LAT-1:0] d_last;
    logic [9:0]        d_addr [RD_LAT];

    logic              dv;
    logic              dl;
    logic [9:0]        da;

    // Stage P: registered product and the flags carried alongside it.
    logic              p_valid;
    logic              p_last;
    logic [9:0]        p_addr;
    logic signed [PW-1:0] prod;

    // Stage A: running sum and the flag that says a new group begins next.
    logic signed [ACC_W-1:0] acc;
    logic                    first_flag;

    // Combinational accumulate, saturate, rescale and clamp.
    logic signed [SW-1:0]    base_ext;
    logic signed [SW-1:0]    prod_ext;
    logic signed [SW-1:0]    sum_wide;
    logic signed [ACC_W-1:0] sum_sat;
    logic signed [ACC_W-1:0] shifted;
    logic [DW-1:0]           clamped;

    // Delay line, so the control bits line up with the memory read data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_valid <= '0;
            d_last  <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                d_addr[i] <= '0;
            end
        end else begin
            d_valid[0] <= in_valid;
            d_last[0]  <= WE_2;
            d_addr[0]  <= BRAM2_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                d_valid[i] <= d_valid[i-1];
                d_last[i]  <= d_last[i-1];
                d_addr[i]  <= d_addr[i-1];
            end
        end
    end

    assign dv = d_valid[RD_LAT-1];
    assign dl = d_last[RD_LAT-1];
    assign da = d_addr[RD_LAT-1];

    // Multiply stage. An empty slot leaves the product and flags untouched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_addr  <= '0;
            prod    <= '0;
        end else begin
            p_valid <= dv;
            if (dv) begin
                p_last <= dl;
                p_addr <= da;
                prod   <= $signed(pixel_in) * $signed(weight_in);
            end
        end
    end

    // Add the product to the running sum, or to zero on the first term of
    // a group, then saturate to the accumulator range instead of wrapping.
    always_comb begin
        base_ext = '0;
        if (!first_flag) begin
            base_ext = {acc[ACC_W-1], acc};
        end
        prod_ext = {{(SW-PW){prod[PW-1]}}, prod};
        sum_wide = base_ext + prod_ext;
        sum_sat  = sum_wide[ACC_W-1:0];
        if (sum_wide[SW-1] != sum_wide[SW-2]) begin
            sum_sat = sum_wide[SW-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Rescale the saturated sum and clamp it into the output word range.
    always_comb begin
        shifted = sum_sat >>> FRAC;
        clamped = shifted[DW-1:0];
        if (shifted > OUT_MAX) begin
            clamped = OUT_MAX[DW-1:0];
        end else if (shifted < OUT_MIN) begin
            clamped = OUT_MIN[DW-1:0];
        end
    end

    // Accumulator update and the BRAM2 write that closes a group.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc         <= '0;
            first_flag  <= 1'b1;
            BRAM2_we    <= 1'b0;
            BRAM2_din   <= '0;
            BRAM2_waddr <= '0;
            write_count <= '0;
        end else begin
            BRAM2_we <= 1'b0;
            if (p_valid) begin
                acc        <= sum_sat;
                first_flag <= p_last;
                if (p_last) begin
                    BRAM2_we    <= 1'b1;
                    BRAM2_waddr <= p_addr;
                    BRAM2_din   <= clamped;
                    write_count <= write_count + 10'd1;
                end
            end
        end
    end

    assign busy = (|d_valid) | p_valid;

endmodule

// File: tb/tb_layer3_mac_accum.sv
// tb_layer3_mac_accum
// Random and directed terms are issued to layer3_mac_accum. A group-level
// reference model computes each expected BRAM2 word when a group is closed
// and queues it; a monitor pops and compares on every BRAM2 write strobe.
// Honours LAYER3_RELU_EN in the same way as the design.
module tb_layer3_mac_accum;

    localparam int DW     = 8;
    localparam int ACC_W  = 24;
    localparam int FRAC   = 4;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic          WE_2 = 1'b0;
    logic [9:0]    BRAM2_addr = '0;
    logic [DW-1:0] pixel_in = '0;
    logic [DW-1:0] weight_in = '0;
    logic [DW-1:0] BRAM2_din;
    logic          BRAM2_we;
    logic [9:0]    BRAM2_waddr;
    logic [9:0]    write_count;
    logic          busy;

    typedef struct {
        logic [9:0]    addr;
        logic [DW-1:0] din;
    } exp_t;

    exp_t   exp_q[$];
    int     n_checks = 0;
    int     n_fail = 0;
    int     exp_count = 0;
    longint grp_sum = 0;
    bit     grp_first = 1'b1;
    logic [DW-1:0] pend_pix = '0;
    logic [DW-1:0] pend_wt = '0;

    layer3_mac_accum #(
        .DW(DW), .ACC_W(ACC_W), .FRAC(FRAC), .RD_LAT(RD_LAT)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .WE_2(WE_2),
        .BRAM2_addr(BRAM2_addr), .pixel_in(pixel_in), .weight_in(weight_in),
        .BRAM2_din(BRAM2_din), .BRAM2_we(BRAM2_we), .BRAM2_waddr(BRAM2_waddr),
        .write_count(write_count), .busy(busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Accumulator saturation at the stated signed range.
    function automatic longint sat_acc(input longint s);
        longint amax = (longint'(1) << (ACC_W-1)) - 1;
        longint amin = -(longint'(1) << (ACC_W-1));
        if (s > amax) return amax;
        if (s < amin) return amin;
        return s;
    endfunction

    // Rescale by FRAC and clamp to the output word range.
    function automatic logic [DW-1:0] to_word(input longint s);
        longint q  = s >>> FRAC;
        longint hi = (longint'(1) << (DW-1)) - 1;
`ifdef LAYER3_RELU_EN
        longint lo = 0;
`else
        longint lo = -(longint'(1) << (DW-1));
`endif
        if (q > hi) q = hi;
        if (q < lo) q = lo;
        return q[DW-1:0];
    endfunction

    // Group-level model: fold one term in, close the group on its last term.
    task automatic model_term(input bit last, input logic [9:0] addr,
                              input logic [DW-1:0] pix, input logic [DW-1:0] wt);
        longint p = longint'($signed(pix)) * longint'($signed(wt));
        exp_t e;
        grp_sum   = sat_acc((grp_first ? 0 : grp_sum) + p);
        grp_first = last;
        if (last) begin
            e.addr = addr;
            e.din  = to_word(grp_sum);
            exp_q.push_back(e);
        end
    endtask

    // One cycle of controller activity; read data of the previous term appears now.
    task automatic apply_stimulus(input bit v, input bit last, input logic [9:0] addr,
                                  input logic [DW-1:0] pix, input logic [DW-1:0] wt);
        @(posedge clk);
        #1;
        in_valid   = v;
        WE_2       = v ? last : 1'($urandom);
        BRAM2_addr = v ? addr : 10'($urandom);
        pixel_in   = pend_pix;
        weight_in  = pend_wt;
        if (v) begin
            pend_pix = pix;
            pend_wt  = wt;
            model_term(last, addr, pix, wt);
        end else begin
            pend_pix = DW'($urandom);
            pend_wt  = DW'($urandom);
        end
    endtask

    task automatic idle();
        apply_stimulus(1'b0, 1'b0, 10'd0, '0, '0);
    endtask

    // Idle until every expected write has appeared, bounded in cycles.
    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 60) begin
            idle();
            guard++;
        end
        repeat (4) idle();
        check_output({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    // Reset pulse: check the cleared outputs while reset is held low.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_output("rst_we",    32'(BRAM2_we),    32'd0);
        check_output("rst_din",   32'(BRAM2_din),   32'd0);
        check_output("rst_waddr", 32'(BRAM2_waddr), 32'd0);
        check_output("rst_count", 32'(write_count), 32'd0);
        check_output("rst_busy",  32'(busy),        32'd0);
        grp_first = 1'b1;
        grp_sum   = 0;
        exp_q.delete();
        exp_count = 0;
        pend_pix  = DW'($urandom);
        pend_wt   = DW'($urandom);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Monitor: every write strobe is matched against the scoreboard.
    always @(negedge clk) begin
        if (rst && BRAM2_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL unexpected_write: got din %0d waddr %0d, expected no write",
                         BRAM2_din, BRAM2_waddr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                exp_count = (exp_count + 1) % 1024;
                check_output("din",   32'(BRAM2_din),   32'(e.din));
                check_output("waddr", 32'(BRAM2_waddr), 32'(e.addr));
                check_output("count", 32'(write_count), 32'(exp_count));
            end
        end
    end

    initial begin
        do_reset();

        // Basic group of four 16x16 terms.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, i == 3, 10'h05, 8'd16, 8'd16);
        drain("basic");
        check_output("basic_count", 32'(write_count), 32'd1);

        // Latency of a single-term group and busy falling afterwards.
        apply_stimulus(1'b1, 1'b1, 10'h09, 8'd32, 8'd8);
        idle();
        @(negedge clk);
        check_output("lat_we_t1", 32'(BRAM2_we), 32'd0);
        check_output("lat_busy_t1", 32'(busy), 32'd1);
        idle();
        @(negedge clk);
        check_output("lat_we_t2", 32'(BRAM2_we), 32'd0);
        idle();
        @(negedge clk);
        check_output("lat_we_t3", 32'(BRAM2_we), 32'd1);
        check_output("lat_din_t3", 32'(BRAM2_din), 32'd16);
        idle();
        @(negedge clk);
        check_output("lat_we_t4", 32'(BRAM2_we), 32'd0);
        check_output("lat_busy_t4", 32'(busy), 32'd0);
        drain("latency");

        // Output saturation.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, i == 3, 10'h10, 8'd127, 8'd127);
        drain("sat");

        // Negative result.
        for (int i = 0; i < 4; i++) apply_stimulus(1'b1, i == 3, 10'h11, 8'hF0, 8'd16);
        drain("sign");

        // Gaps inside a group, then a back-to-back single-term group.
        apply_stimulus(1'b1, 1'b0, 10'h20, 8'd16, 8'd16);
        repeat (3) idle();
        apply_stimulus(1'b1, 1'b1, 10'h20, 8'd16, 8'd16);
        apply_stimulus(1'b1, 1'b1, 10'h21, 8'd16, 8'd16);
        drain("gap_b2b");

        // Reset in the middle of a group discards its partial sum.
        apply_stimulus(1'b1, 1'b0, 10'h30, 8'd16, 8'd16);
        apply_stimulus(1'b1, 1'b0, 10'h30, 8'd16, 8'd16);
        do_reset();
        apply_stimulus(1'b1, 1'b1, 10'h31, 8'd16, 8'd16);
        drain("mid_reset");
        check_output("mid_reset_count", 32'(write_count), 32'd1);

        // Long group driving the accumulator into saturation.
        for (int i = 0; i < 600; i++) apply_stimulus(1'b1, i == 599, 10'h3FF, 8'h80, 8'h80);
        drain("acc_sat");

        // Randomized groups with random gaps.
        for (int g = 0; g < 150; g++) begin
            int len = $urandom_range(1, 6);
            logic [9:0] addr = 10'($urandom);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) idle();
                apply_stimulus(1'b1, i == len - 1, addr, DW'($urandom), DW'($urandom));
            end
        end
        drain("random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
